// File: rtl/call_request_latch.sv
`default_nettype none
// call_request_latch (rev 1.0): debounces and latches elevator calls, issues one call at a time
// using an up/down sweep, and stretches the door-blocked bit to a minimum hold time.
module call_request_latch #(
    parameter int DEBOUNCE_CYCLES  = 4,
    parameter int CNT_W            = 3,
    parameter int DOOR_HOLD_CYCLES = 8,
    parameter int HOLD_W           = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] btn_raw,
    input  logic       blk_raw,
    input  logic [0:3] fpos,
    output logic [0:3] F,
    output logic [2:0] pending
);

    localparam logic [1:0] FLOOR1   = 2'd0;
    localparam logic [1:0] FLOOR2   = 2'd1;
    localparam logic [1:0] FLOOR3   = 2'd2;
    localparam logic       DIR_DOWN = 1'b0;
    localparam logic       DIR_UP   = 1'b1;

    logic [3:0]        raw_in;
    logic [3:0]        sync_q1;
    logic [3:0]        sync_q2;
    logic [3:0]        deb;
    logic [2:0]        deb_btn_prev;
    logic [2:0]        rise;
    logic [2:0]        serve;
    logic              door_open;
    logic              door_prev;
    logic [1:0]        cur_floor;
    logic              dir;
    logic              dir_next;
    logic [HOLD_W-1:0] hold;
    logic              up_hit;
    logic              dn_hit;
    logic [1:0]        up_flr;
    logic [1:0]        dn_flr;
    logic              sel_hit;
    logic [1:0]        sel_flr;
    logic [2:0]        req;

    // Bit 3 carries the obstruction sensor, bits 2:0 the floor buttons.
    assign raw_in = {blk_raw, btn_raw};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 4'b0000;
            sync_q2 <= 4'b0000;
        end else begin
            sync_q1 <= raw_in;
            sync_q2 <= sync_q1;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_debounce
        logic [CNT_W-1:0] cnt;
        logic             val;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
                val <= 1'b0;
            end else if (sync_q2[i] != val) begin
                if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    val <= ~val;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end

        assign deb[i] = val;
    end

    assign rise = deb[2:0] & ~deb_btn_prev;

    // Case equality so that any unknown bit on fpos never matches a service code.
    always_comb begin
        serve[0]  = (fpos === 4'b1001);
        serve[1]  = (fpos === 4'b0101);
        serve[2]  = (fpos === 4'b0011);
        door_open = (fpos[3] === 1'b1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_btn_prev <= 3'b000;
            pending      <= 3'b000;
        end else begin
            deb_btn_prev <= deb[2:0];
            pending      <= (pending | rise) & ~serve;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_floor <= FLOOR1;
        end else if (fpos[0:2] === 3'b100) begin
            cur_floor <= FLOOR1;
        end else if (fpos[0:2] === 3'b010) begin
            cur_floor <= FLOOR2;
        end else if (fpos[0:2] === 3'b001) begin
            cur_floor <= FLOOR3;
        end
    end

    // Nearest pending floor on each side of the car.
    always_comb begin
        up_hit = 1'b0;
        up_flr = cur_floor;
        dn_hit = 1'b0;
        dn_flr = cur_floor;
        case (cur_floor)
            FLOOR1: begin
                up_hit = pending[1] | pending[2];
                up_flr = pending[1] ? FLOOR2 : FLOOR3;
            end
            FLOOR2: begin
                up_hit = pending[2];
                up_flr = FLOOR3;
                dn_hit = pending[0];
                dn_flr = FLOOR1;
            end
            default: begin
                dn_hit = pending[1] | pending[0];
                dn_flr = pending[1] ? FLOOR2 : FLOOR1;
            end
        endcase
    end

    always_comb begin
        sel_hit  = 1'b0;
        sel_flr  = cur_floor;
        dir_next = dir;
        if (door_open) begin
            sel_hit = 1'b0;
        end else if (pending[cur_floor]) begin
            sel_hit = 1'b1;
        end else if (dir == DIR_UP) begin
            if (up_hit) begin
                sel_hit = 1'b1;
                sel_flr = up_flr;
            end else if (dn_hit) begin
                sel_hit  = 1'b1;
                sel_flr  = dn_flr;
                dir_next = DIR_DOWN;
            end
        end else begin
            if (dn_hit) begin
                sel_hit = 1'b1;
                sel_flr = dn_flr;
            end else if (up_hit) begin
                sel_hit  = 1'b1;
                sel_flr  = up_flr;
                dir_next = DIR_UP;
            end
        end
        req = sel_hit ? (3'b001 << sel_flr) : 3'b000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            door_prev <= 1'b0;
            hold      <= '0;
        end else begin
            door_prev <= door_open;
            if (door_open && !door_prev) begin
                hold <= HOLD_W'(DOOR_HOLD_CYCLES);
            end else if (hold != '0) begin
                hold <= hold - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            F   <= 4'b0000;
            dir <= DIR_UP;
        end else begin
            F   <= {req[0], req[1], req[2], deb[3] | (hold != '0)};
            dir <= dir_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_call_request_latch.sv
`default_nettype none
// tb_call_request_latch: scenario tasks plus randomized traffic against a behavioural model.
module tb_call_request_latch;

    localparam int DEB  = 4;
    localparam int HOLD = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] btn_raw;
    logic       blk_raw;
    logic [0:3] fpos;
    logic [0:3] F;
    logic [2:0] pending;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    bit m_h1[4];
    bit m_h2[4];
    bit m_deb[4];
    int m_streak[4];
    bit m_debprev[3];
    bit m_pend[3];
    int m_cur;
    bit m_up;
    bit m_call[3];
    bit m_blk;
    int m_hold;
    bit m_doorprev;

    call_request_latch #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (3),
        .DOOR_HOLD_CYCLES(HOLD),
        .HOLD_W          (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_raw(btn_raw),
        .blk_raw(blk_raw),
        .fpos   (fpos),
        .F      (F),
        .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_h1[i] = 0; m_h2[i] = 0; m_deb[i] = 0; m_streak[i] = 0;
        end
        for (int f = 0; f < 3; f++) begin
            m_debprev[f] = 0; m_pend[f] = 0; m_call[f] = 0;
        end
        m_cur = 0; m_up = 1; m_blk = 0; m_hold = 0; m_doorprev = 0;
    endtask

    task automatic model_step();
        logic [3:0] raw;
        logic [0:3] code;
        bit door, known, nxt_up;
        bit rise[3];
        int tgt, bu, bd, ones, at_f;
        raw  = {blk_raw, btn_raw};
        door = (fpos[3] === 1'b1);
        for (int f = 0; f < 3; f++) rise[f] = m_deb[f] && !m_debprev[f];
        // choose the call from the state held before this edge
        tgt = -1; bu = -1; bd = -1; nxt_up = m_up;
        for (int f = 0; f < 3; f++) begin
            if (m_pend[f]) begin
                if (f > m_cur && (bu < 0 || (f - m_cur) < (bu - m_cur))) bu = f;
                if (f < m_cur && (bd < 0 || (m_cur - f) < (m_cur - bd))) bd = f;
            end
        end
        if (!door) begin
            if (m_pend[m_cur]) tgt = m_cur;
            else if (m_up) begin
                if (bu >= 0) tgt = bu;
                else if (bd >= 0) begin tgt = bd; nxt_up = 0; end
            end else begin
                if (bd >= 0) tgt = bd;
                else if (bu >= 0) begin tgt = bu; nxt_up = 1; end
            end
        end
        for (int f = 0; f < 3; f++) m_call[f] = (tgt == f);
        m_up  = nxt_up;
        m_blk = m_deb[3] || (m_hold > 0);
        if (door && !m_doorprev) m_hold = HOLD;
        else if (m_hold > 0) m_hold = m_hold - 1;
        m_doorprev = door;
        for (int f = 0; f < 3; f++) begin
            code = 4'b0001;
            code[f] = 1'b1;
            if (fpos === code) m_pend[f] = 0;
            else if (rise[f]) m_pend[f] = 1;
            m_debprev[f] = m_deb[f];
        end
        ones = 0; at_f = -1; known = 1;
        for (int f = 0; f < 3; f++) begin
            if (fpos[f] === 1'b1) begin ones++; at_f = f; end
            else if (fpos[f] !== 1'b0) known = 0;
        end
        if (known && ones == 1) m_cur = at_f;
        for (int i = 0; i < 4; i++) begin
            if (m_h2[i] != m_deb[i]) begin
                m_streak[i]++;
                if (m_streak[i] >= DEB) begin m_deb[i] = !m_deb[i]; m_streak[i] = 0; end
            end else m_streak[i] = 0;
            m_h2[i] = m_h1[i];
            m_h1[i] = raw[i];
        end
    endtask

    function automatic logic [0:3] exp_f();
        return {m_call[0], m_call[1], m_call[2], m_blk};
    endfunction

    function automatic logic [2:0] exp_p();
        return {m_pend[2], m_pend[1], m_pend[0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; btn_raw = 3'b000; blk_raw = 1'b0; fpos = 4'b0000;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (F !== 4'b0000) begin bad++; $display("FAIL reset_F got=%b want=0000", F); end
        total++; if (pending !== 3'b000) begin bad++; $display("FAIL reset_pending got=%b want=000", pending); end
        repeat (3) tick();
        total++; if (F !== 4'b0000 || pending !== 3'b000) begin
            bad++; $display("FAIL reset_idle F=%b pending=%b want 0000/000", F, pending);
        end
    endtask

    task automatic test_latency();
        logic [0:3] wf;
        logic [2:0] wp;
        do_reset();
        btn_raw = 3'b100;
        for (int e = 0; e < 10; e++) begin
            tick();
            wp = (e >= 6) ? 3'b100 : 3'b000;
            wf = (e >= 7) ? 4'b0010 : 4'b0000;
            total++; if (pending !== wp) begin bad++; $display("FAIL latency_pending edge=%0d got=%b want=%b", e, pending, wp); end
            total++; if (F !== wf) begin bad++; $display("FAIL latency_F edge=%0d got=%b want=%b", e, F, wf); end
        end
    endtask

    task automatic test_short_pulse();
        do_reset();
        btn_raw = 3'b001;
        for (int c = 0; c < 14; c++) begin
            if (c == 3) btn_raw = 3'b000;
            tick();
            total++; if (pending !== 3'b000 || F !== 4'b0000) begin
                bad++; $display("FAIL short_pulse cyc=%0d F=%b pending=%b want 0000/000", c, F, pending);
            end
        end
    endtask

    task automatic test_bounce();
        int cyc, sets, r;
        bit prev;
        do_reset();
        cyc = 0; sets = 0; prev = 0;
        while (cyc < 20) begin
            btn_raw = 3'b010;
            r = $urandom_range(1, 2);
            repeat (r) begin tick(); cyc++; if (pending[1] && !prev) sets++; prev = pending[1]; end
            btn_raw = 3'b000;
            r = $urandom_range(1, 2);
            repeat (r) begin tick(); cyc++; if (pending[1] && !prev) sets++; prev = pending[1]; end
        end
        btn_raw = 3'b010;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (pending[1] && !prev) sets++;
            prev = pending[1];
            total++; if (F !== exp_f() || pending !== exp_p()) begin
                bad++; $display("FAIL bounce_model cyc=%0d F=%b/%b pending=%b/%b", c, F, exp_f(), pending, exp_p());
            end
        end
        total++; if (sets != 1) begin bad++; $display("FAIL bounce_sets got=%0d want=1", sets); end
        total++; if (F !== 4'b0100) begin bad++; $display("FAIL bounce_F got=%b want=0100", F); end
    endtask

    task automatic test_sweep();
        do_reset();
        fpos = 4'b0100;
        repeat (2) tick();
        btn_raw = 3'b101;
        repeat (9) tick();
        total++; if (pending !== 3'b101) begin bad++; $display("FAIL sweep_pending got=%b want=101", pending); end
        total++; if (F !== 4'b0010) begin bad++; $display("FAIL sweep_up_F got=%b want=0010", F); end
        btn_raw = 3'b000;
        fpos = 4'b0011;
        tick();
        total++; if (pending !== 3'b001) begin bad++; $display("FAIL sweep_serve got=%b want=001", pending); end
        total++; if (F[0:2] !== 3'b000) begin bad++; $display("FAIL sweep_door_calls got=%b want=000", F[0:2]); end
        repeat (3) tick();
        fpos = 4'b0010;
        tick();
        total++; if (F[0:2] !== 3'b100) begin bad++; $display("FAIL sweep_down_F got=%b want=100", F[0:2]); end
        total++; if (F !== exp_f() || pending !== exp_p()) begin
            bad++; $display("FAIL sweep_model F=%b/%b pending=%b/%b", F, exp_f(), pending, exp_p());
        end
    endtask

    task automatic test_door_hold();
        int hi;
        do_reset();
        repeat (2) tick();
        fpos = 4'b0001;
        hi = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (F[3] === 1'b1) hi++;
            total++; if (F[0:2] !== 3'b000 || F !== exp_f()) begin
                bad++; $display("FAIL hold_model cyc=%0d F=%b want=%b", c, F, exp_f());
            end
        end
        total++; if (hi != HOLD) begin bad++; $display("FAIL hold_len got=%0d want=%0d", hi, HOLD); end
        fpos = 4'b0000;
        blk_raw = 1'b1;
        hi = 0;
        for (int c = 0; c < 25; c++) begin
            if (c == 10) blk_raw = 1'b0;
            tick();
            if (F[3] === 1'b1) hi++;
        end
        total++; if (hi != 10) begin bad++; $display("FAIL blk_len got=%0d want=10", hi); end
        // door opening together with a 10-cycle obstruction: hold bridges into the debounced blocked bit
        fpos = 4'b0001;
        blk_raw = 1'b1;
        hi = 0;
        for (int c = 0; c < 25; c++) begin
            if (c == 10) blk_raw = 1'b0;
            tick();
            if (F[3] === 1'b1) hi++;
            total++; if (F !== exp_f()) begin bad++; $display("FAIL hold_blk_model cyc=%0d F=%b want=%b", c, F, exp_f()); end
        end
        total++; if (hi != 15) begin bad++; $display("FAIL hold_blk_len got=%0d want=15", hi); end
    endtask

    task automatic test_same_floor_and_reset();
        do_reset();
        fpos = 4'b1001;
        btn_raw = 3'b001;
        for (int c = 0; c < 12; c++) begin
            tick();
            total++; if (pending[0] !== 1'b0) begin bad++; $display("FAIL same_floor cyc=%0d pending=%b want=xx0", c, pending); end
        end
        fpos = 4'b0100;
        btn_raw = 3'b100;
        repeat (9) tick();
        total++; if (F !== 4'b0010 || pending !== 3'b100) begin
            bad++; $display("FAIL pre_reset F=%b pending=%b want 0010/100", F, pending);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++; if (F !== 4'b0000) begin bad++; $display("FAIL async_reset_F got=%b want=0000", F); end
        total++; if (pending !== 3'b000) begin bad++; $display("FAIL async_reset_pending got=%b want=000", pending); end
        model_reset();
        btn_raw = 3'b000; fpos = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [0:3] fp_set[12];
        fp_set = '{4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b1001, 4'b0101,
                   4'b0011, 4'b0001, 4'b1100, 4'b0x00, 4'b100x, 4'bz001};
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 3; i++)
                if ($urandom_range(0, 11) == 0) btn_raw[i] = ~btn_raw[i];
            if ($urandom_range(0, 19) == 0) blk_raw = ~blk_raw;
            if ($urandom_range(0, 5) == 0) fpos = fp_set[$urandom_range(0, 11)];
            tick();
            total++; if (F !== exp_f() || pending !== exp_p()) begin
                bad++; $display("FAIL random cyc=%0d F=%b/%b pending=%b/%b", c, F, exp_f(), pending, exp_p());
            end
            total++; if ($countones(F[0:2]) > 1) begin bad++; $display("FAIL onehot cyc=%0d calls=%b want <=1 set", c, F[0:2]); end
        end
    endtask

    initial begin
        rst_n = 1'b0; btn_raw = 3'b000; blk_raw = 1'b0; fpos = 4'b0000;
        model_reset();
        test_reset();
        test_latency();
        test_short_pulse();
        test_bounce();
        test_sweep();
        test_door_hold();
        test_same_floor_and_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
